// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: sends Reset then Enable Data Reporting, checks each
// response byte, and recovers through timeout, bounded retry and a sticky fail state.
module ps2_mouse_init_ctrl #(
  parameter int POWERUP_CYC = 1000000,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       stream_en,
  output logic       init_done,
  output logic       init_fail,
  output logic [1:0] retry_cnt,
  output logic [3:0] state_dbg
);
  localparam logic [3:0] S_POWERUP   = 4'd0;
  localparam logic [3:0] S_SEND_RST  = 4'd1;
  localparam logic [3:0] S_WAIT_TX   = 4'd2;
  localparam logic [3:0] S_WAIT_ACK1 = 4'd3;
  localparam logic [3:0] S_WAIT_BAT  = 4'd4;
  localparam logic [3:0] S_WAIT_ID   = 4'd5;
  localparam logic [3:0] S_SEND_EN   = 4'd6;
  localparam logic [3:0] S_WAIT_ACK2 = 4'd7;
  localparam logic [3:0] S_STREAM    = 4'd8;
  localparam logic [3:0] S_FAIL      = 4'd9;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic [25:0] PU_LIM = 26'(POWERUP_CYC);
  localparam logic [25:0] TO_LIM = 26'(TIMEOUT_CYC);

  logic [3:0]  state_reg, state_next;
  logic [25:0] timer_reg, timer_next;
  logic [1:0]  retry_reg, retry_next;
  logic        cmd_sel_reg, cmd_sel_next;
  logic        tx_req_reg, tx_req_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        stream_en_reg, init_done_reg;
  logic        timeout, retry_evt, resend_evt, can_retry;

  always_comb begin
    state_next   = state_reg;
    retry_next   = retry_reg;
    cmd_sel_next = cmd_sel_reg;
    tx_req_next  = 1'b0;
    tx_data_next = tx_data_reg;
    retry_evt    = 1'b0;
    resend_evt   = 1'b0;
    timeout      = (timer_reg >= TO_LIM);
    can_retry    = (int'(retry_reg) < MAX_RETRY);

    case (state_reg)
      S_POWERUP: if (timer_reg >= PU_LIM) state_next = S_SEND_RST;
      S_SEND_RST, S_SEND_EN: begin
        if (!tx_busy) begin
          tx_req_next  = 1'b1;
          cmd_sel_next = (state_reg == S_SEND_EN);
          tx_data_next = (state_reg == S_SEND_EN) ? CMD_ENABLE : CMD_RESET;
          state_next   = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (tx_done)                 state_next = cmd_sel_reg ? S_WAIT_ACK2 : S_WAIT_ACK1;
        else if (tx_err || timeout)  retry_evt  = 1'b1;
      end
      S_WAIT_ACK1, S_WAIT_ACK2: begin
        if (rx_valid) begin
          if (rx_data == RSP_ACK)
            state_next = (state_reg == S_WAIT_ACK2) ? S_STREAM : S_WAIT_BAT;
          else if (rx_data == RSP_RESEND)
            resend_evt = 1'b1;
          else
            retry_evt = 1'b1;
        end else if (timeout) begin
          retry_evt = 1'b1;
        end
      end
      S_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_data == RSP_BAT_OK) state_next = S_WAIT_ID;
          else                       retry_evt  = 1'b1;
        end else if (timeout) begin
          retry_evt = 1'b1;
        end
      end
      S_WAIT_ID: begin
        if (rx_valid) begin
          if (rx_data == RSP_ID) state_next = S_SEND_EN;
          else                   retry_evt  = 1'b1;
        end else if (timeout) begin
          retry_evt = 1'b1;
        end
      end
      S_STREAM, S_FAIL: ;
      default: state_next = S_POWERUP;
    endcase

    // A resend re-issues the command just sent; any other failure restarts the full sequence.
    if (retry_evt || resend_evt) begin
      if (can_retry) begin
        retry_next = retry_reg + 2'd1;
        state_next = (resend_evt && cmd_sel_reg) ? S_SEND_EN : S_SEND_RST;
      end else begin
        state_next = S_FAIL;
      end
    end

    if (state_next == S_STREAM && state_reg != S_STREAM) retry_next = 2'd0;

    if (restart) begin
      state_next   = S_POWERUP;
      retry_next   = 2'd0;
      tx_req_next  = 1'b0;
      tx_data_next = tx_data_reg;
      cmd_sel_next = cmd_sel_reg;
    end

    // Timer restarts on every state entry; saturates so long idle states cannot wrap it.
    if (restart || state_next != state_reg) timer_next = '0;
    else if (timer_reg == '1)              timer_next = timer_reg;
    else                                   timer_next = timer_reg + 26'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_POWERUP;
      timer_reg     <= '0;
      retry_reg     <= 2'd0;
      cmd_sel_reg   <= 1'b0;
      tx_req_reg    <= 1'b0;
      tx_data_reg   <= 8'h00;
      stream_en_reg <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      retry_reg     <= retry_next;
      cmd_sel_reg   <= cmd_sel_next;
      tx_req_reg    <= tx_req_next;
      tx_data_reg   <= tx_data_next;
      stream_en_reg <= !restart && (state_reg == S_STREAM);
      init_done_reg <= !restart && (init_done_reg || state_reg == S_STREAM);
    end
  end

  assign tx_req    = tx_req_reg;
  assign tx_data   = tx_data_reg;
  assign stream_en = stream_en_reg;
  assign init_done = init_done_reg;
  assign init_fail = (state_reg == S_FAIL);
  assign retry_cnt = retry_reg;
  assign state_dbg = state_reg;
endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: directed scenarios plus randomized device faults,
// checked against a command-level model of the init handshake.
module tb_ps2_mouse_init_ctrl;
  localparam int P  = 20;
  localparam int TO = 1000;
  localparam int MR = 3;
  localparam logic [3:0] ST_POWERUP = 4'd0, ST_WAIT_BAT = 4'd4, ST_STREAM = 4'd8, ST_FAIL = 4'd9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0, tx_done = 1'b0, tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       stream_en, init_done, init_fail;
  logic [1:0] retry_cnt;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  // Model of the handshake at the level of commands and outcomes
  int         m_retry;
  logic [7:0] m_cmd;
  bit         m_fail, m_stream;

  ps2_mouse_init_ctrl #(.POWERUP_CYC(P), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .stream_en(stream_en), .init_done(init_done), .init_fail(init_fail),
    .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_retry = 0; m_cmd = 8'hFF; m_fail = 0; m_stream = 0;
  endtask

  task automatic model_fault(input bit resend);
    if (m_retry < MR) begin
      m_retry++;
      if (!resend) m_cmd = 8'hFF;
    end else begin
      m_fail = 1;
    end
  endtask

  task automatic model_ok();
    if (m_cmd == 8'hFF) m_cmd = 8'hF4;
    else begin m_stream = 1; m_retry = 0; end
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (tx_req !== 1'b1 && n < 5000) begin tick(); n++; end
    check({tag, "_req_seen"}, tx_req, 1'b1);
    $display("req %s: data=%h retry=%0d after %0d cycles", tag, tx_data, retry_cnt, n);
  endtask

  task automatic do_tx(input bit err, input string tag);
    logic [7:0] d;
    d = tx_data;
    tx_busy = 1'b1;
    tick();
    check({tag, "_req_pulse"}, tx_req, 1'b0);
    tick();
    check({tag, "_data_hold"}, tx_data, d);
    if (err) tx_err = 1'b1; else tx_done = 1'b1;
    tick();
    tx_done = 1'b0; tx_err = 1'b0; tx_busy = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  // fault: 0 none, 1 tx_err, 2 resend, 3 bad ack, 4 BAT=FC, 5 bad ID
  task automatic exchange(input int fault, input string tag);
    logic [7:0] cmd;
    cmd = m_cmd;
    check({tag, "_cmd"}, tx_data, cmd);
    check({tag, "_retry"}, retry_cnt, m_retry);
    $display("xfer %s: cmd=%h fault=%0d", tag, cmd, fault);
    do_tx(fault == 1, tag);
    if (fault == 1) begin model_fault(0); return; end
    tick();
    if (fault == 2) begin send_rx(8'hFE); model_fault(1); return; end
    if (fault == 3) begin send_rx(8'h12); model_fault(0); return; end
    send_rx(8'hFA);
    if (cmd == 8'hFF) begin
      tick();
      send_rx(fault == 4 ? 8'hFC : 8'hAA);
      if (fault == 4) begin model_fault(0); return; end
      tick();
      send_rx(fault == 5 ? 8'h03 : 8'h00);
      if (fault == 5) begin model_fault(0); return; end
    end
    model_ok();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_st_stream"}, state_dbg, ST_STREAM);
    check({tag, "_en_late"}, stream_en, 1'b0);
    tick();
    check({tag, "_stream_en"}, stream_en, 1'b1);
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_retry_clr"}, retry_cnt, 2'd0);
  endtask

  task automatic check_fail(input string tag);
    int c;
    c = 0;
    check({tag, "_init_fail"}, init_fail, 1'b1);
    check({tag, "_st_fail"}, state_dbg, ST_FAIL);
    repeat (60) begin tick(); if (tx_req === 1'b1) c++; end
    check({tag, "_no_req"}, c, 0);
    check({tag, "_fail_sticky"}, init_fail, 1'b1);
  endtask

  task automatic pulse_restart(input string tag);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_reset();
    check({tag, "_rs_state"}, state_dbg, ST_POWERUP);
    check({tag, "_rs_flags"}, {stream_en, init_done, init_fail, retry_cnt, tx_req}, 6'd0);
  endtask

  initial begin
    int n, cnt, f;
    model_reset();
    // Asynchronous reset assertion, no clock edge needed
    #2 rst = 1'b0;
    #1;
    check("rst_state", state_dbg, ST_POWERUP);
    check("rst_outs", {tx_req, tx_data, stream_en, init_done, init_fail, retry_cnt}, 14'd0);
    repeat (3) tick();
    @(negedge clk) rst = 1'b1;

    // Nominal: first request lands P+2 edges after release (cycle P+1 counting from 0)
    wait_req("nom", n);
    check("nom_powerup_lat", n, P + 2);
    exchange(0, "nom_rst");
    wait_req("nom_en", n);
    exchange(0, "nom_en");
    check_stream("nom");

    // Resend on the first Reset
    pulse_restart("fe");
    wait_req("fe", n);
    check("fe_restart_lat", n, P + 2);
    exchange(2, "fe_rst");
    while (!m_stream && n < 5000) begin wait_req("fe_n", n); exchange(0, "fe_n"); end
    check_stream("fe");

    // BAT failure then recovery
    pulse_restart("bat");
    wait_req("bat", n);
    exchange(4, "bat_rst");
    while (!m_stream && n < 5000) begin wait_req("bat_n", n); exchange(0, "bat_n"); end
    check_stream("bat");

    // Silent device after Enable: timeouts until the retry budget is spent
    pulse_restart("to");
    wait_req("to", n);
    for (int k = 0; k < 4; k++) begin
      exchange(0, "to_rst");
      wait_req("to_en", n);
      check("to_en_cmd", tx_data, m_cmd);
      do_tx(0, "to_en");
      model_fault(0);
      if (!m_fail) begin
        wait_req("to_resend", n);
        // ack wait entered at the tx_done edge; limit hit TO edges later, +1 to SEND_RST, +1 to tx_req
        check("to_gap", n, TO + 2);
      end
    end
    repeat (TO + 3) tick();
    check_fail("to");

    // Restart while waiting for BAT
    pulse_restart("rb");
    wait_req("rb", n);
    exchange(2, "rb_rst");
    wait_req("rb2", n);
    do_tx(0, "rb2");
    tick();
    send_rx(8'hFA);
    check("rb_in_bat", state_dbg, ST_WAIT_BAT);
    check("rb_retry", retry_cnt, 2'd1);
    pulse_restart("rb");

    // Asynchronous reset in the middle of a transmission
    wait_req("ar", n);
    exchange(2, "ar_rst");
    wait_req("ar2", n);
    tx_busy = 1'b1;
    tick();
    #3 rst = 1'b0;
    #1;
    check("ar_state", state_dbg, ST_POWERUP);
    check("ar_outs", {tx_req, tx_data, stream_en, init_done, init_fail, retry_cnt}, 14'd0);
    tick();
    tx_busy = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();

    // Transmitter busy while the Enable command is pending
    wait_req("bz", n);
    check("bz_powerup_lat", n, P + 2);
    check("bz_cmd", tx_data, 8'hFF);
    do_tx(0, "bz");
    tick(); send_rx(8'hFA);
    tick(); send_rx(8'hAA);
    tick();
    tx_busy = 1'b1;
    send_rx(8'h00);
    cnt = 0;
    repeat (50) begin if (tx_req === 1'b1) cnt++; tick(); end
    check("bz_hold", cnt, 0);
    tx_busy = 1'b0;
    tick();
    check("bz_release_req", tx_req, 1'b1);
    check("bz_en_cmd", tx_data, 8'hF4);
    do_tx(0, "bz_en");
    tick();
    send_rx(8'hFA);
    check_stream("bz");

    // Randomized device behaviour
    for (int ep = 0; ep < 8; ep++) begin
      pulse_restart("rnd");
      cnt = 0;
      while (!m_fail && !m_stream && cnt < 40) begin
        wait_req("rnd", n);
        f = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
        if (m_cmd == 8'hF4 && f > 3) f = 3;
        exchange(f, "rnd");
        cnt++;
      end
      check("rnd_bounded", cnt < 40, 1'b1);
      if (m_stream) check_stream("rnd");
      else          check_fail("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
